// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - TLB refill walker: arbitration, PTE read, victim write, flush
module tlb_refill_ctrl #(
  parameter int          N_ENT   = 8,
  parameter int          VPN_W   = 20,
  parameter int          PFN_W   = 3,
  parameter logic [31:0] PT_BASE = 32'h0000_2000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 f_miss_req,
  input  logic [31:0]                          f_miss_va,
  input  logic                                 m_miss_req,
  input  logic [31:0]                          m_miss_va,
  input  logic                                 tlb_flush,
  output logic                                 mem_rd_req,
  output logic [31:0]                          mem_rd_addr,
  input  logic                                 mem_rd_ack,
  input  logic [31:0]                          mem_rd_data,
  output logic                                 f_miss_done,
  output logic                                 m_miss_done,
  output logic                                 miss_fault,
  output logic [N_ENT*(VPN_W+PFN_W+4)-1:0]     TLB
);

  localparam int E_W   = VPN_W + PFN_W + 4;
  localparam int IDX_W = $clog2(N_ENT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RD_PTE, S_WRITE, S_DONE, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_m_q, gnt_m_d;   // 1: mem-stage owns the walk, 0: fetch
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [PFN_W+1:0]   pte_q, pte_d;       // {pfn, writable, cacheable}
  logic               kill_q, kill_d;     // flush landed while the PTE read was in flight
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [E_W-1:0]     tlb_q [N_ENT];
  logic [E_W-1:0]     tlb_d [N_ENT];

  logic               hit;
  logic               free_found;
  logic [IDX_W-1:0]   victim;

  // Only the PTE fields and the page number are meaningful; the rest is ignored.
  logic unused_bits;
  assign unused_bits = ^{mem_rd_data[31:12+PFN_W], mem_rd_data[11:3],
                         f_miss_va[31-VPN_W:0], m_miss_va[31-VPN_W:0]};

  // State, walk context and TLB array registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_m_q <= 1'b0;
      vpn_q   <= '0;
      pte_q   <= '0;
      kill_q  <= 1'b0;
      rr_q    <= '0;
      for (int i = 0; i < N_ENT; i++) tlb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gnt_m_q <= gnt_m_d;
      vpn_q   <= vpn_d;
      pte_q   <= pte_d;
      kill_q  <= kill_d;
      rr_q    <= rr_d;
      for (int i = 0; i < N_ENT; i++) tlb_q[i] <= tlb_d[i];
    end
  end

  // Hit detection on the latched VPN and victim choice (lowest invalid, else round-robin)
  always_comb begin
    hit        = 1'b0;
    free_found = 1'b0;
    victim     = rr_q;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (!tlb_q[i][3]) begin
        free_found = 1'b1;
        victim     = IDX_W'(i);
      end
      if (tlb_q[i][3] && (tlb_q[i][E_W-1 -: VPN_W] == vpn_q)) hit = 1'b1;
    end
  end

  // Walk FSM: next state, array updates and outputs
  always_comb begin
    state_d     = state_q;
    gnt_m_d     = gnt_m_q;
    vpn_d       = vpn_q;
    pte_d       = pte_q;
    kill_d      = kill_q;
    rr_d        = rr_q;
    for (int i = 0; i < N_ENT; i++) tlb_d[i] = tlb_q[i];
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    f_miss_done = 1'b0;
    m_miss_done = 1'b0;
    miss_fault  = 1'b0;

    if (tlb_flush) begin
      for (int i = 0; i < N_ENT; i++) tlb_d[i][3] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        // Mem stage wins: it holds the older instruction.
        if (m_miss_req) begin
          gnt_m_d = 1'b1;
          vpn_d   = m_miss_va[31 -: VPN_W];
          state_d = S_LOOKUP;
        end else if (f_miss_req) begin
          gnt_m_d = 1'b0;
          vpn_d   = f_miss_va[31 -: VPN_W];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // A flush this cycle invalidates whatever we would have hit on.
        state_d = (hit && !tlb_flush) ? S_DONE : S_RD_PTE;
      end
      S_RD_PTE: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = PT_BASE + 32'({vpn_q, 2'b00});
        if (tlb_flush) kill_d = 1'b1;
        if (mem_rd_ack) begin
          if (kill_q || tlb_flush) begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else if (mem_rd_data[0]) begin
            pte_d   = {mem_rd_data[12 +: PFN_W], mem_rd_data[1], mem_rd_data[2]};
            state_d = S_WRITE;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_WRITE: begin
        if (tlb_flush) begin
          state_d = S_IDLE;
        end else begin
          tlb_d[victim] = {vpn_q, pte_q[PFN_W+1:2], 1'b1, 1'b1, pte_q[1], pte_q[0]};
          if (!free_found) rr_d = rr_q + IDX_W'(1);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        m_miss_done = gnt_m_q;
        f_miss_done = !gnt_m_q;
        state_d     = S_IDLE;
      end
      S_FAULT: begin
        m_miss_done = gnt_m_q;
        f_miss_done = !gnt_m_q;
        miss_fault  = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flatten the entry array onto the TLB bus
  always_comb begin
    TLB = '0;
    for (int i = 0; i < N_ENT; i++) TLB[i*E_W +: E_W] = tlb_q[i];
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// tb/tb_tlb_refill_ctrl.sv - directed and randomized bench for tlb_refill_ctrl
module tb_tlb_refill_ctrl;

  localparam int          N   = 8;
  localparam logic [31:0] PTB = 32'h0000_2000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         f_miss_req = 1'b0;
  logic [31:0]  f_miss_va = '0;
  logic         m_miss_req = 1'b0;
  logic [31:0]  m_miss_va = '0;
  logic         tlb_flush = 1'b0;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_ack = 1'b0;
  logic [31:0]  mem_rd_data = '0;
  logic         f_miss_done;
  logic         m_miss_done;
  logic         miss_fault;
  logic [215:0] TLB;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: entry contents as plain arrays plus the replacement pointer
  logic [19:0] r_vpn [N];
  logic [2:0]  r_pfn [N];
  bit          r_v [N];
  bit          r_w [N];
  bit          r_c [N];
  int          rr = 0;
  logic [31:0] exp_rd [$];
  logic [31:0] got_rd [$];

  always #5 clk = ~clk;

  tlb_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .f_miss_req(f_miss_req), .f_miss_va(f_miss_va),
    .m_miss_req(m_miss_req), .m_miss_va(m_miss_va),
    .tlb_flush(tlb_flush),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .f_miss_done(f_miss_done), .m_miss_done(m_miss_done),
    .miss_fault(miss_fault), .TLB(TLB)
  );

  // Page table contents: every seventh page is absent, other fields derived from the VPN
  function automatic logic [31:0] pte_of(input logic [19:0] vpn);
    if (vpn % 7 == 6) return 32'h0;
    return {17'b0, vpn[2:0] ^ 3'd6, 9'b0, vpn[4], ~vpn[3], 1'b1};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      r_v[i] = 0; r_vpn[i] = '0; r_pfn[i] = '0; r_w[i] = 0; r_c[i] = 0;
    end
    rr = 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < N; i++) r_v[i] = 0;
  endfunction

  // Serve one miss; returns cycles from its grant edge to its done cycle
  function automatic int model_serve(input logic [19:0] vpn, input int dly, output bit fault);
    logic [31:0] pte;
    int vic;
    fault = 0;
    for (int i = 0; i < N; i++)
      if (r_v[i] && r_vpn[i] == vpn) return 2;
    exp_rd.push_back(PTB + 32'(vpn) * 4);
    pte = pte_of(vpn);
    if (!pte[0]) begin
      fault = 1;
      return 3 + dly;
    end
    vic = -1;
    for (int i = 0; i < N; i++) begin
      if (!r_v[i]) begin
        vic = i;
        break;
      end
    end
    if (vic < 0) begin
      vic = rr;
      rr = (rr + 1) % N;
    end
    r_v[vic] = 1; r_vpn[vic] = vpn; r_pfn[vic] = pte[14:12]; r_w[vic] = pte[1]; r_c[vic] = pte[2];
    return 4 + dly;
  endfunction

  function automatic logic [215:0] model_tlb();
    logic [215:0] t;
    t = '0;
    for (int i = 0; i < N; i++)
      if (r_v[i]) t[27*i +: 27] = {r_vpn[i], r_pfn[i], 1'b1, 1'b1, r_w[i], r_c[i]};
    return t;
  endfunction

  // Invalid entries only carry their valid bit; the rest is don't-care
  function automatic logic [215:0] mask_tlb(input logic [215:0] t);
    for (int i = 0; i < N; i++)
      if (!t[27*i+3]) t[27*i +: 27] = '0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise the chosen requests, answer PTE reads after dly cycles, optionally flush in the first read cycle
  task automatic run(input bit f_on, input logic [19:0] fvpn, input bit m_on, input logic [19:0] mvpn,
                     input int dly, input bit kill);
    int n, wait_cnt, start, f_exp, m_exp, f_got, m_got;
    bit f_fx, m_fx, f_fg, m_fg, f_pend, m_pend, both;
    logic [31:0] off;
    exp_rd.delete();
    got_rd.delete();
    start = 0; f_exp = -1; m_exp = -1; f_fx = 0; m_fx = 0; f_fg = 0; m_fg = 0;
    if (kill) begin
      exp_rd.push_back(PTB + 32'(m_on ? mvpn : fvpn) * 4);
      model_flush();
      start = 3 + dly;
    end
    if (m_on) begin
      m_exp = start + model_serve(mvpn, dly, m_fx);
      start = m_exp + 1;
    end
    if (f_on) f_exp = start + model_serve(fvpn, dly, f_fx);

    f_miss_va = {fvpn, 12'($urandom)};
    m_miss_va = {mvpn, 12'($urandom)};
    f_miss_req = f_on; m_miss_req = m_on;
    f_pend = f_on; m_pend = m_on;
    n = 0; wait_cnt = -1; f_got = -1; m_got = -1; both = 0;
    while ((f_pend || m_pend) && n < 100) begin
      @(posedge clk); #1;
      n++;
      mem_rd_ack = 1'b0; mem_rd_data = '0; tlb_flush = 1'b0;
      if (kill && n == 2) tlb_flush = 1'b1;
      if (f_miss_done && m_miss_done) both = 1;
      if (m_miss_done) begin m_got = n; m_fg = miss_fault; m_miss_req = 1'b0; m_pend = 0; end
      if (f_miss_done) begin f_got = n; f_fg = miss_fault; f_miss_req = 1'b0; f_pend = 0; end
      if (mem_rd_req) begin
        if (wait_cnt < 0) begin
          got_rd.push_back(mem_rd_addr);
          wait_cnt = dly;
        end
        if (wait_cnt == 0) begin
          off = (mem_rd_addr - PTB) >> 2;
          mem_rd_ack = 1'b1;
          mem_rd_data = pte_of(off[19:0]);
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
    f_miss_req = 1'b0; m_miss_req = 1'b0;
    chk("all_done", {f_pend, m_pend}, 0);
    if (m_on) begin
      chk("m_done_cycle", m_got, m_exp);
      chk("m_fault", m_fg, m_fx);
    end
    if (f_on) begin
      chk("f_done_cycle", f_got, f_exp);
      chk("f_fault", f_fg, f_fx);
    end
    chk("both_done", both, 0);
    chk("rd_count", got_rd.size(), exp_rd.size());
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      chk("rd_addr", got_rd[i], exp_rd[i]);
    chk("tlb", mask_tlb(TLB), model_tlb());
    @(posedge clk); #1;
    chk("idle_after", {mem_rd_req, f_miss_done, m_miss_done, miss_fault}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    logic [19:0] va, vb;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {mem_rd_req, f_miss_done, m_miss_done, miss_fault}, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_tlb", TLB, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch miss on page 5, PTE 0x3003 at 0x2014
    chk("t1_pte", pte_of(20'h5), 32'h0000_3003);
    run(1, 20'h5, 0, 20'h0, 0, 0);
    chk("t1_entry0", TLB[26:0], {20'h5, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0});

    // Simultaneous requests: mem first, fetch five cycles later
    run(1, 20'h11, 1, 20'h22, 0, 0);

    // Absent page faults without touching the array
    run(1, 20'h6, 0, 20'h0, 1, 0);
    run(0, 20'h0, 1, 20'h6, 0, 0);

    // Fill the array and keep replacing past the round-robin wrap
    for (int i = 0; i < 20; i++)
      run(0, 20'h0, 1, 20'h200 + 20'(i), $urandom_range(0, 2), 0);

    // Flush in the first read cycle with a late ack: walk is discarded and redone
    run(1, 20'h31, 0, 20'h0, 3, 1);
    chk("t5_entry0", TLB[26:0], {20'h31, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1});
    for (int i = 1; i < N; i++) chk("t5_valid", TLB[27*i+3], 0);

    // Same page from both stages: one PTE read, fetch hits
    run(1, 20'h44, 1, 20'h44, 1, 0);

    // Randomized traffic with occasional idle flushes
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 2);
      va = 20'($urandom_range(0, 20));
      vb = 20'($urandom_range(0, 20));
      run(sel != 1, va, sel != 0, vb, $urandom_range(0, 3), 0);
      if ($urandom_range(0, 5) == 0) begin
        tlb_flush = 1'b1;
        @(posedge clk); #1;
        tlb_flush = 1'b0;
        model_flush();
        chk("idle_flush", mask_tlb(TLB), model_tlb());
      end
    end

    // Reset during a walk: outputs clear at once and the late ack is ignored
    m_miss_va = {20'h77, 12'h0};
    m_miss_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_req_before", mem_rd_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", {mem_rd_req, mem_rd_addr}, 0);
    chk("rst_mid_tlb", TLB, 0);
    mem_rd_ack = 1'b1;
    mem_rd_data = 32'h0000_3003;
    m_miss_req = 1'b0;
    @(posedge clk); #1;
    mem_rd_ack = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_after", {mem_rd_req, f_miss_done, m_miss_done, miss_fault}, 0);
    chk("rst_mid_tlb_after", TLB, 0);
    run(1, 20'h9, 0, 20'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
